// File: rtl/polara_noc_gen_pkg.sv
// Shared definitions for the Polara NoC traffic generator: FSM states,
// channel select codes, fixed header fields and payload pattern units.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_DST_X_WIDTH
`define MSG_DST_X_WIDTH 8
`endif
`ifndef MSG_DST_Y_WIDTH
`define MSG_DST_Y_WIDTH 8
`endif
`ifndef MSG_TYPE_INV_FWD
`define MSG_TYPE_INV_FWD 8'd16
`endif

package polara_noc_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_GAP     = 3'd3,
    ST_DONE    = 3'd4
  } gen_state_e;

  localparam logic [1:0] NOC_SEL_NONE = 2'd0;
  localparam logic [1:0] NOC_SEL_1    = 2'd1;
  localparam logic [1:0] NOC_SEL_2    = 2'd2;
  localparam logic [1:0] NOC_SEL_3    = 2'd3;

  localparam logic [13:0] HDR_CHIPID = 14'd0;
  localparam logic [3:0]  HDR_FBITS  = 4'd0;
  localparam logic [5:0]  HDR_RSVD   = 6'd0;

  // Two-bit units replicated across the flit width to form the payloads
  localparam logic [1:0] PATTERN_A_UNIT = 2'b01;
  localparam logic [1:0] PATTERN_B_UNIT = 2'b10;

endpackage

// File: rtl/polara_noc_hdr_builder.sv
// Combinational NoC header assembly from the latched destination,
// effective payload length and packet tag.
module polara_noc_hdr_builder
  import polara_noc_gen_pkg::*;
#(
  parameter int DATA_WIDTH = `NOC_DATA_WIDTH
) (
  input  logic [`MSG_DST_X_WIDTH-1:0] dst_x_i,
  input  logic [`MSG_DST_Y_WIDTH-1:0] dst_y_i,
  input  logic [7:0]                  len_i,
  input  logic [7:0]                  tag_i,
  output logic [DATA_WIDTH-1:0]       hdr_o
);

  always_comb begin
    hdr_o        = '0;
    hdr_o[63:50] = HDR_CHIPID;
    hdr_o[49:42] = dst_x_i;
    hdr_o[41:34] = dst_y_i;
    hdr_o[33:30] = HDR_FBITS;
    hdr_o[29:22] = len_i;
    hdr_o[21:14] = `MSG_TYPE_INV_FWD;
    hdr_o[13:6]  = tag_i;
    hdr_o[5:0]   = HDR_RSVD;
  end

endmodule

// File: rtl/polara_noc_traffic_gen.sv
// NoC stimulus generator: header + alternating A/B payload flits + idle gap
// on a selectable channel. Optional return-traffic sink: POLARA_NOC_TRAFFIC_GEN_RX_SINK_EN.
module polara_noc_traffic_gen
  import polara_noc_gen_pkg::*;
#(
  parameter int DATA_WIDTH  = `NOC_DATA_WIDTH,
  parameter int MAX_PAYLOAD = 6,
  parameter int GAP_W       = 8,
  parameter int CNT_W       = 32,
  parameter logic [DATA_WIDTH-1:0] PATTERN_A = {(DATA_WIDTH/2){PATTERN_A_UNIT}},
  parameter logic [DATA_WIDTH-1:0] PATTERN_B = {(DATA_WIDTH/2){PATTERN_B_UNIT}}
) (
  input  logic                        chipset_clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [1:0]                  cfg_noc_sel,
  input  logic [`MSG_DST_X_WIDTH-1:0] cfg_dst_x,
  input  logic [`MSG_DST_Y_WIDTH-1:0] cfg_dst_y,
  input  logic [7:0]                  cfg_payload_len,
  input  logic [CNT_W-1:0]            cfg_pkt_limit,
  input  logic [GAP_W-1:0]            cfg_gap,
  output logic [DATA_WIDTH-1:0]       chipset_intf_data_noc1,
  output logic [DATA_WIDTH-1:0]       chipset_intf_data_noc2,
  output logic [DATA_WIDTH-1:0]       chipset_intf_data_noc3,
  output logic                        chipset_intf_val_noc1,
  output logic                        chipset_intf_val_noc2,
  output logic                        chipset_intf_val_noc3,
  input  logic                        chipset_intf_rdy_noc1,
  input  logic                        chipset_intf_rdy_noc2,
  input  logic                        chipset_intf_rdy_noc3,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_W-1:0]            pkt_count,
  output logic [CNT_W-1:0]            flit_count
`ifdef POLARA_NOC_TRAFFIC_GEN_RX_SINK_EN
  ,
  input  logic [DATA_WIDTH-1:0]       intf_chipset_data_noc1,
  input  logic [DATA_WIDTH-1:0]       intf_chipset_data_noc2,
  input  logic [DATA_WIDTH-1:0]       intf_chipset_data_noc3,
  input  logic                        intf_chipset_val_noc1,
  input  logic                        intf_chipset_val_noc2,
  input  logic                        intf_chipset_val_noc3,
  output logic                        intf_chipset_rdy_noc1,
  output logic                        intf_chipset_rdy_noc2,
  output logic                        intf_chipset_rdy_noc3,
  output logic [CNT_W-1:0]            rx_flit_count
`endif
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  gen_state_e                  state_q, state_d;
  logic [1:0]                  sel_q;
  logic [`MSG_DST_X_WIDTH-1:0] dst_x_q;
  logic [`MSG_DST_Y_WIDTH-1:0] dst_y_q;
  logic [7:0]                  len_q, idx_q, idx_d;
  logic [GAP_W-1:0]            gap_q, gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]            limit_q, pkt_q, pkt_d, flit_q, flit_d;
  logic                        latch_cfg, flit_val, rdy_sel, fire;
  logic [DATA_WIDTH-1:0]       hdr, flit_data;

  polara_noc_hdr_builder #(.DATA_WIDTH(DATA_WIDTH)) u_hdr (
    .dst_x_i (dst_x_q),
    .dst_y_i (dst_y_q),
    .len_i   (len_q),
    .tag_i   (pkt_q[7:0]),
    .hdr_o   (hdr)
  );

  assign flit_val  = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD);
  assign flit_data = (state_q == ST_HEADER) ? hdr : (idx_q[0] ? PATTERN_B : PATTERN_A);
  assign fire      = flit_val && rdy_sel;

  always_comb begin
    chipset_intf_val_noc1  = 1'b0;
    chipset_intf_val_noc2  = 1'b0;
    chipset_intf_val_noc3  = 1'b0;
    chipset_intf_data_noc1 = '0;
    chipset_intf_data_noc2 = '0;
    chipset_intf_data_noc3 = '0;
    rdy_sel                = 1'b0;
    case (sel_q)
      NOC_SEL_1: begin
        chipset_intf_val_noc1  = flit_val;
        chipset_intf_data_noc1 = flit_val ? flit_data : '0;
        rdy_sel                = chipset_intf_rdy_noc1;
      end
      NOC_SEL_2: begin
        chipset_intf_val_noc2  = flit_val;
        chipset_intf_data_noc2 = flit_val ? flit_data : '0;
        rdy_sel                = chipset_intf_rdy_noc2;
      end
      NOC_SEL_3: begin
        chipset_intf_val_noc3  = flit_val;
        chipset_intf_data_noc3 = flit_val ? flit_data : '0;
        rdy_sel                = chipset_intf_rdy_noc3;
      end
      default: ;
    endcase
  end

  // Every entry into HEADER re-latches config, including back-to-back packets
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_cnt_d = gap_cnt_q;
    pkt_d     = pkt_q;
    flit_d    = fire ? flit_q + 1'b1 : flit_q;
    latch_cfg = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && cfg_noc_sel != NOC_SEL_NONE) begin
          state_d   = ST_HEADER;
          latch_cfg = 1'b1;
        end
      end
      ST_HEADER, ST_PAYLOAD: begin
        if (fire) begin
          if ((state_q == ST_HEADER && len_q == 8'd0) ||
              (state_q == ST_PAYLOAD && idx_q == len_q - 8'd1)) begin
            pkt_d = pkt_q + 1'b1;
            if (limit_q != '0 && pkt_d == limit_q) begin
              state_d = ST_DONE;
            end else if (!enable) begin
              state_d = ST_IDLE;
            end else if (gap_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q - 1'b1;
            end else if (cfg_noc_sel != NOC_SEL_NONE) begin
              state_d   = ST_HEADER;
              latch_cfg = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (state_q == ST_HEADER) begin
            state_d = ST_PAYLOAD;
            idx_d   = 8'd0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end else if (enable && cfg_noc_sel != NOC_SEL_NONE) begin
          state_d   = ST_HEADER;
          latch_cfg = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (!enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge chipset_clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= NOC_SEL_NONE;
      dst_x_q   <= '0;
      dst_y_q   <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      limit_q   <= '0;
      idx_q     <= '0;
      gap_cnt_q <= '0;
      pkt_q     <= '0;
      flit_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_cnt_q <= gap_cnt_d;
      pkt_q     <= pkt_d;
      flit_q    <= flit_d;
      if (latch_cfg) begin
        sel_q   <= cfg_noc_sel;
        dst_x_q <= cfg_dst_x;
        dst_y_q <= cfg_dst_y;
        len_q   <= (cfg_payload_len > MAX_LEN) ? MAX_LEN : cfg_payload_len;
        gap_q   <= cfg_gap;
        limit_q <= cfg_pkt_limit;
      end
    end
  end

  assign busy       = flit_val || (state_q == ST_GAP);
  assign done       = (state_q == ST_DONE);
  assign pkt_count  = pkt_q;
  assign flit_count = flit_q;

`ifdef POLARA_NOC_TRAFFIC_GEN_RX_SINK_EN
  logic [CNT_W-1:0] rx_cnt_q;
  logic             rx_data_unused;

  // Returning traffic is always accepted and only counted
  assign intf_chipset_rdy_noc1 = 1'b1;
  assign intf_chipset_rdy_noc2 = 1'b1;
  assign intf_chipset_rdy_noc3 = 1'b1;
  assign rx_data_unused = ^{intf_chipset_data_noc1, intf_chipset_data_noc2, intf_chipset_data_noc3};

  always_ff @(posedge chipset_clk) begin
    if (!rst_n) begin
      rx_cnt_q <= '0;
    end else begin
      rx_cnt_q <= rx_cnt_q + CNT_W'(intf_chipset_val_noc1) + CNT_W'(intf_chipset_val_noc2)
                           + CNT_W'(intf_chipset_val_noc3);
    end
  end

  assign rx_flit_count = rx_cnt_q;
`endif

endmodule

// File: tb/tb_polara_noc_traffic_gen.sv
// Self-checking bench for polara_noc_traffic_gen: table of packet configs
// plus directed sequences for backpressure, gaps, enable drop and reset.
module tb_polara_noc_traffic_gen;
  import polara_noc_gen_pkg::*;

  localparam logic [63:0] PAT_A = 64'h5555_5555_5555_5555;
  localparam logic [63:0] PAT_B = 64'hAAAA_AAAA_AAAA_AAAA;

  logic        clk = 1'b0, rstN = 1'b0, enable = 1'b0;
  logic [1:0]  cfgSel = 2'd0;
  logic [7:0]  cfgX = 8'd0, cfgY = 8'd0, cfgLen = 8'd0, cfgGap = 8'd0;
  logic [31:0] cfgLimit = 32'd0;
  logic [63:0] data1, data2, data3;
  logic        val1, val2, val3;
  logic        rdy1 = 1'b1, rdy2 = 1'b1, rdy3 = 1'b1;
  logic        busy, done;
  logic [31:0] pktCount, flitCount;
`ifdef POLARA_NOC_TRAFFIC_GEN_RX_SINK_EN
  logic [63:0] rxData1 = '0, rxData2 = '0, rxData3 = '0;
  logic        rxVal1 = 1'b0, rxVal2 = 1'b0, rxVal3 = 1'b0;
  logic        rxRdy1, rxRdy2, rxRdy3;
  logic [31:0] rxFlitCount;
`endif

  int checks = 0, fails = 0;
  int cycleCnt = 0, strayCnt = 0, stallBad = 0;
  logic [1:0]  monSel = 2'd0;
  logic        monV, monR, stallPending = 1'b0, bpMode = 1'b0;
  logic [63:0] monD, stallData = '0;
  logic [63:0] capData[$];
  int          capCycle[$];

  polara_noc_traffic_gen dut (
    .chipset_clk(clk), .rst_n(rstN), .enable(enable),
    .cfg_noc_sel(cfgSel), .cfg_dst_x(cfgX), .cfg_dst_y(cfgY),
    .cfg_payload_len(cfgLen), .cfg_pkt_limit(cfgLimit), .cfg_gap(cfgGap),
    .chipset_intf_data_noc1(data1), .chipset_intf_data_noc2(data2), .chipset_intf_data_noc3(data3),
    .chipset_intf_val_noc1(val1), .chipset_intf_val_noc2(val2), .chipset_intf_val_noc3(val3),
    .chipset_intf_rdy_noc1(rdy1), .chipset_intf_rdy_noc2(rdy2), .chipset_intf_rdy_noc3(rdy3),
    .busy(busy), .done(done), .pkt_count(pktCount), .flit_count(flitCount)
`ifdef POLARA_NOC_TRAFFIC_GEN_RX_SINK_EN
    ,
    .intf_chipset_data_noc1(rxData1), .intf_chipset_data_noc2(rxData2), .intf_chipset_data_noc3(rxData3),
    .intf_chipset_val_noc1(rxVal1), .intf_chipset_val_noc2(rxVal2), .intf_chipset_val_noc3(rxVal3),
    .intf_chipset_rdy_noc1(rxRdy1), .intf_chipset_rdy_noc2(rxRdy2), .intf_chipset_rdy_noc3(rxRdy3),
    .rx_flit_count(rxFlitCount)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Ready toggles every cycle on NoC2 while backpressure mode is on
  always @(posedge clk) begin
    if (bpMode) begin
      #1 rdy2 = ~rdy2;
    end
  end

  // Channel monitor: records accepted flits, stray traffic and stall stability
  always @(negedge clk) begin
    if (rstN) begin
      if (monSel != 2'd1 && (val1 || data1 != '0)) strayCnt++;
      if (monSel != 2'd2 && (val2 || data2 != '0)) strayCnt++;
      if (monSel != 2'd3 && (val3 || data3 != '0)) strayCnt++;
      monV = 1'b0; monR = 1'b0; monD = '0;
      case (monSel)
        2'd1: begin monV = val1; monR = rdy1; monD = data1; end
        2'd2: begin monV = val2; monR = rdy2; monD = data2; end
        2'd3: begin monV = val3; monR = rdy3; monD = data3; end
        default: ;
      endcase
      if (stallPending && (!monV || monD !== stallData)) stallBad++;
      stallPending = monV && !monR;
      stallData    = monD;
      if (monV && monR) begin
        capData.push_back(monD);
        capCycle.push_back(cycleCnt);
      end
    end
  end

  function automatic logic [63:0] expHeader(logic [7:0] x, logic [7:0] y, logic [7:0] len, logic [7:0] tag);
    return {14'd0, x, y, 4'd0, len, 8'd16, tag, 6'd0};
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearCapture(logic [1:0] sel);
    monSel = sel;
    capData.delete();
    capCycle.delete();
    strayCnt = 0;
    stallBad = 0;
    stallPending = 1'b0;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    enable = 1'b0;
    tick(2);
    rstN = 1'b1;
    tick(1);
  endtask

  task automatic applyStimulus(logic [1:0] sel, logic [7:0] x, logic [7:0] y, logic [7:0] len,
                               logic [31:0] limit, logic [7:0] gap);
    cfgSel = sel; cfgX = x; cfgY = y; cfgLen = len; cfgLimit = limit; cfgGap = gap;
    clearCapture(sel);
    enable = 1'b1;
  endtask

  task automatic waitDone(int bound);
    for (int i = 0; i < bound && !done; i++) tick(1);
    checkOutput("doneReached", {63'd0, done}, 64'd1);
  endtask

  task automatic waitCaptured(int n, int bound);
    for (int i = 0; i < bound && capData.size() < n; i++) tick(1);
    checkOutput("captureReached", 64'(capData.size() >= n), 64'd1);
  endtask

  task automatic waitIdle(int bound);
    for (int i = 0; i < bound && busy; i++) tick(1);
    checkOutput("idleReached", {63'd0, busy}, 64'd0);
  endtask

  // Compares one packet of captured flits starting at index 'start'
  task automatic checkPacket(string tag, int start, logic [7:0] x, logic [7:0] y,
                             logic [7:0] lenField, logic [7:0] pktTag);
    logic [63:0] act;
    act = (start < capData.size()) ? capData[start] : 64'hx;
    checkOutput($sformatf("%s hdr", tag), act, expHeader(x, y, lenField, pktTag));
    for (int i = 0; i < int'(lenField); i++) begin
      act = (start + 1 + i < capData.size()) ? capData[start + 1 + i] : 64'hx;
      checkOutput($sformatf("%s pl%0d", tag, i), act, i[0] ? PAT_B : PAT_A);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  dstX, dstY, len;
    logic [31:0] limit;
    logic [7:0]  expLenField;
    int          expFlits;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{sel: 2'd2, dstX: 8'd4, dstY: 8'd1, len: 8'd6,   limit: 32'd1, expLenField: 8'd6, expFlits: 7};
    vecs[1] = '{sel: 2'd2, dstX: 8'd2, dstY: 8'd5, len: 8'd0,   limit: 32'd3, expLenField: 8'd0, expFlits: 3};
    vecs[2] = '{sel: 2'd3, dstX: 8'd7, dstY: 8'd2, len: 8'd9,   limit: 32'd1, expLenField: 8'd6, expFlits: 7};
    vecs[3] = '{sel: 2'd1, dstX: 8'd1, dstY: 8'd3, len: 8'd1,   limit: 32'd2, expLenField: 8'd1, expFlits: 4};
    vecs[4] = '{sel: 2'd1, dstX: 8'd9, dstY: 8'd8, len: 8'd200, limit: 32'd1, expLenField: 8'd6, expFlits: 7};

    doReset();
    checkOutput("rstVal", {61'd0, val1, val2, val3}, 64'd0);
    checkOutput("rstData", data1 | data2 | data3, 64'd0);
    checkOutput("rstBusyDone", {62'd0, busy, done}, 64'd0);
    checkOutput("rstPkt", {32'd0, pktCount}, 64'd0);
    checkOutput("rstFlit", {32'd0, flitCount}, 64'd0);

    for (int v = 0; v < 5; v++) begin
      doReset();
      applyStimulus(vecs[v].sel, vecs[v].dstX, vecs[v].dstY, vecs[v].len, vecs[v].limit, 8'd0);
      checkOutput($sformatf("v%0d noValSameCycle", v), {61'd0, val1, val2, val3}, 64'd0);
      waitDone(300);
      checkOutput($sformatf("v%0d flits", v), 64'(capData.size()), 64'(vecs[v].expFlits));
      for (int p = 0; p < int'(vecs[v].limit); p++)
        checkPacket($sformatf("v%0d p%0d", v, p), p * (1 + int'(vecs[v].expLenField)),
                    vecs[v].dstX, vecs[v].dstY, vecs[v].expLenField, p[7:0]);
      if (capData.size() > 0)
        checkOutput($sformatf("v%0d consecutive", v), 64'(capCycle[capData.size()-1] - capCycle[0]),
                    64'(capData.size() - 1));
      checkOutput($sformatf("v%0d pktCount", v), {32'd0, pktCount}, {32'd0, vecs[v].limit});
      checkOutput($sformatf("v%0d flitCount", v), {32'd0, flitCount}, 64'(vecs[v].expFlits));
      checkOutput($sformatf("v%0d busy", v), {63'd0, busy}, 64'd0);
      checkOutput($sformatf("v%0d stray", v), 64'(strayCnt), 64'd0);
      enable = 1'b0;
      tick(1);
      checkOutput($sformatf("v%0d doneClear", v), {63'd0, done}, 64'd0);
      checkOutput($sformatf("v%0d pktKept", v), {32'd0, pktCount}, {32'd0, vecs[v].limit});
    end

    // Backpressure: NoC2 ready toggling, flits must hold while stalled
    doReset();
    bpMode = 1'b1;
    applyStimulus(2'd2, 8'd4, 8'd1, 8'd6, 32'd1, 8'd0);
    waitDone(300);
    bpMode = 1'b0;
    tick(1);
    rdy2 = 1'b1;
    checkOutput("bp flits", 64'(capData.size()), 64'd7);
    checkPacket("bp", 0, 8'd4, 8'd1, 8'd6, 8'd0);
    checkOutput("bp stallStable", 64'(stallBad), 64'd0);
    checkOutput("bp flitCount", {32'd0, flitCount}, 64'd7);
    checkOutput("bp pktCount", {32'd0, pktCount}, 64'd1);
    enable = 1'b0;
    tick(1);

    // Unlimited packets on NoC1 with a 3-cycle gap
    doReset();
    applyStimulus(2'd1, 8'd3, 8'd6, 8'd2, 32'd0, 8'd3);
    waitCaptured(9, 200);
    enable = 1'b0;
    for (int p = 0; p < 3; p++) checkPacket($sformatf("gap p%0d", p), p * 3, 8'd3, 8'd6, 8'd2, p[7:0]);
    if (capData.size() >= 7) begin
      checkOutput("gap1 spacing", 64'(capCycle[3] - capCycle[2]), 64'd4);
      checkOutput("gap2 spacing", 64'(capCycle[6] - capCycle[5]), 64'd4);
    end
    waitIdle(50);
    checkOutput("gap pktCount", {32'd0, pktCount}, 64'd3);
    checkOutput("gap flitCount", {32'd0, flitCount}, 64'd9);
    checkOutput("gap stray", 64'(strayCnt), 64'd0);

    // Enable dropped while payload index 2 is presented
    doReset();
    applyStimulus(2'd2, 8'd4, 8'd1, 8'd6, 32'd0, 8'd0);
    waitCaptured(3, 100);
    enable = 1'b0;
    waitIdle(50);
    tick(2);
    checkOutput("drop flits", 64'(capData.size()), 64'd7);
    checkPacket("drop", 0, 8'd4, 8'd1, 8'd6, 8'd0);
    checkOutput("drop pktCount", {32'd0, pktCount}, 64'd1);
    checkOutput("drop done", {63'd0, done}, 64'd0);

    // Reset in the middle of a packet aborts it immediately
    doReset();
    applyStimulus(2'd3, 8'd1, 8'd1, 8'd6, 32'd1, 8'd0);
    waitCaptured(3, 100);
    rstN = 1'b0;
    tick(1);
    checkOutput("midRst val", {61'd0, val1, val2, val3}, 64'd0);
    checkOutput("midRst flit", {32'd0, flitCount}, 64'd0);
    checkOutput("midRst busy", {63'd0, busy}, 64'd0);
    enable = 1'b0;
    rstN = 1'b1;
    tick(1);

`ifdef POLARA_NOC_TRAFFIC_GEN_RX_SINK_EN
    // Return-traffic sink counts every valid flit on all three channels
    doReset();
    checkOutput("rx rst", {32'd0, rxFlitCount}, 64'd0);
    checkOutput("rx rdy", {61'd0, rxRdy1, rxRdy2, rxRdy3}, 64'd7);
    rxVal1 = 1'b1; rxVal2 = 1'b1; rxVal3 = 1'b1;
    tick(4);
    rxVal1 = 1'b0; rxVal2 = 1'b0; rxVal3 = 1'b0;
    tick(2);
    checkOutput("rx count", {32'd0, rxFlitCount}, 64'd12);
`endif

    $display("test done: total=%0d bad=%0d", checks, fails);
    $finish;
  end

endmodule
